// File: rtl/qos_pkg.sv
// Definitions shared by the QoS blocks: default widths, holding-slot state
// encoding and the class-ID one-hot decode.
package qos_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 8;

  // Widest supported configuration; callers cast the decode down to NUM_CH.
  localparam int MAX_CH   = 16;
  localparam int ID_MAX_W = 4;

  localparam logic EMPTY = 1'b0;
  localparam logic HELD  = 1'b1;

  function automatic logic [MAX_CH-1:0] onehot(input logic [ID_MAX_W-1:0] id);
    logic [MAX_CH-1:0] v;
    v     = {MAX_CH{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/conector_entrada_param_if.sv
// Word/handshake bundle between the ingress source, the input connector and
// the per-class FIFOs.
interface conector_entrada_param_if
  import qos_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ID_W   = $clog2(NUM_CH),
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                    PUSHDATOENTRADA;
  logic [ID_W-1:0]         ID;
  logic [DATA_W-1:0]       DATOENTRADA;
  logic [NUM_CH-1:0]       FULL;
  logic                    READY;
  logic [NUM_CH-1:0]       CFPUSH;
  logic [DATA_W-1:0]       CFDATO;
  logic [NUM_CH*CNT_W-1:0] DROPCNT;

  modport master (
    output PUSHDATOENTRADA, ID, DATOENTRADA, FULL,
    input  READY, CFPUSH, CFDATO, DROPCNT
  );

  modport slave (
    input  PUSHDATOENTRADA, ID, DATOENTRADA, FULL,
    output READY, CFPUSH, CFDATO, DROPCNT
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET_L,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q = cnt_q;

endmodule

// File: rtl/conector_entrada_param.sv
// Input connector: steers one class-tagged word per cycle into its class FIFO
// through a single-entry holding slot, backpressuring or dropping on full.
module conector_entrada_param
  import qos_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int ID_W         = $clog2(NUM_CH),
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DROP_ON_FULL = 0
) (
  input logic                     CLK,
  input logic                     RESET_L,
  conector_entrada_param_if.slave bus
);

  logic              hold_v_q, hold_v_d;
  logic [ID_W-1:0]   hold_id_q, hold_id_d;
  logic [DATA_W-1:0] hold_d_q, hold_d_d;

  logic [NUM_CH-1:0] hold_oh_s;
  logic [NUM_CH-1:0] cfpush_s;
  logic [NUM_CH-1:0] inc_s;
  logic              full_sel_s;
  logic              fire_s;
  logic              drop_s;
  logic              release_s;
  logic              ready_s;
  logic              accept_s;

  logic [CNT_W-1:0]        cnt_s [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] dropcnt_s;

  // Releasing the slot in a cycle makes room for a same-cycle accept, which
  // is what lets the connector sustain one word per clock.
  always_comb begin
    hold_oh_s  = NUM_CH'(onehot(ID_MAX_W'(hold_id_q)));
    full_sel_s = bus.FULL[hold_id_q];
    fire_s     = (hold_v_q == HELD) && !full_sel_s;
    drop_s     = (DROP_ON_FULL != 0) && (hold_v_q == HELD) && full_sel_s;
    release_s  = fire_s || drop_s;
    ready_s    = RESET_L && ((hold_v_q == EMPTY) || release_s);
    accept_s   = bus.PUSHDATOENTRADA && ready_s;
  end

  always_comb begin
    hold_v_d  = hold_v_q;
    hold_id_d = hold_id_q;
    hold_d_d  = hold_d_q;
    if (accept_s) begin
      hold_v_d  = HELD;
      hold_id_d = bus.ID;
      hold_d_d  = bus.DATOENTRADA;
    end else if (release_s) begin
      hold_v_d  = EMPTY;
    end else begin
      hold_v_d  = hold_v_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      hold_v_q  <= EMPTY;
      hold_id_q <= {ID_W{1'b0}};
      hold_d_q  <= {DATA_W{1'b0}};
    end else begin
      hold_v_q  <= hold_v_d;
      hold_id_q <= hold_id_d;
      hold_d_q  <= hold_d_d;
    end
  end

  always_comb begin
    cfpush_s = hold_oh_s & {NUM_CH{fire_s && RESET_L}};
    inc_s    = hold_oh_s & {NUM_CH{drop_s}};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_drop_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .INC     (inc_s[k]),
      .Q       (cnt_s[k])
    );
    assign dropcnt_s[k*CNT_W +: CNT_W] = cnt_s[k];
  end

  assign bus.READY   = ready_s;
  assign bus.CFPUSH  = cfpush_s;
  assign bus.CFDATO  = RESET_L ? hold_d_q : {DATA_W{1'b0}};
  assign bus.DROPCNT = dropcnt_s;

endmodule

// File: tb/tb_conector_entrada_param.sv
// Bench for conector_entrada_param: a hold-mode and a drop-mode instance,
// directed vector table, hand sequences, then randomized traffic vs a model.
module tb_conector_entrada_param;

  localparam int NCH   = 4;
  localparam int IDW   = 2;
  localparam int DW    = 6;
  localparam int CW_BP = 8;
  localparam int CW_DR = 3;

  logic CLK = 1'b0;
  logic RESET_L;

  always #5 CLK = ~CLK;

  conector_entrada_param_if #(.NUM_CH(NCH), .ID_W(IDW), .DATA_W(DW), .CNT_W(CW_BP)) bp_if ();
  conector_entrada_param_if #(.NUM_CH(NCH), .ID_W(IDW), .DATA_W(DW), .CNT_W(CW_DR)) dr_if ();

  conector_entrada_param #(
    .NUM_CH(NCH), .ID_W(IDW), .DATA_W(DW), .CNT_W(CW_BP), .DROP_ON_FULL(0)
  ) u_bp (
    .CLK(CLK), .RESET_L(RESET_L), .bus(bp_if.slave)
  );

  conector_entrada_param #(
    .NUM_CH(NCH), .ID_W(IDW), .DATA_W(DW), .CNT_W(CW_DR), .DROP_ON_FULL(1)
  ) u_dr (
    .CLK(CLK), .RESET_L(RESET_L), .bus(dr_if.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       push;
    logic [1:0] id;
    logic [5:0] data;
    logic [3:0] full;
    logic       exp_ready;
    logic [3:0] exp_push;
    logic [5:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  // Reference model: a one-word buffer per instance plus per-class drop tallies.
  bit         m_valid [2];
  int         m_id    [2];
  logic [5:0] m_data  [2];
  int         m_cnt   [2][NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int i, input logic push, input logic [1:0] id,
                       input logic [5:0] d, input logic [3:0] full);
    if (i == 0) begin
      bp_if.PUSHDATOENTRADA = push;
      bp_if.ID              = id;
      bp_if.DATOENTRADA     = d;
      bp_if.FULL            = full;
    end else begin
      dr_if.PUSHDATOENTRADA = push;
      dr_if.ID              = id;
      dr_if.DATOENTRADA     = d;
      dr_if.FULL            = full;
    end
  endtask

  task automatic chk_out(input int i, input string tag, input logic ready,
                         input logic [3:0] push, input logic [5:0] data);
    if (i == 0) begin
      chk({tag, ".bp.ready"},  64'(bp_if.READY),  64'(ready));
      chk({tag, ".bp.cfpush"}, 64'(bp_if.CFPUSH), 64'(push));
      chk({tag, ".bp.cfdato"}, 64'(bp_if.CFDATO), 64'(data));
    end else begin
      chk({tag, ".dr.ready"},  64'(dr_if.READY),  64'(ready));
      chk({tag, ".dr.cfpush"}, 64'(dr_if.CFPUSH), 64'(push));
      chk({tag, ".dr.cfdato"}, 64'(dr_if.CFDATO), 64'(data));
    end
  endtask

  function automatic logic [63:0] act_cnt(input int i);
    return (i == 0) ? 64'(bp_if.DROPCNT) : 64'(dr_if.DROPCNT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_id[i]    = 0;
      m_data[i]  = 6'h00;
      for (int k = 0; k < NCH; k++) m_cnt[i][k] = 0;
    end
  endtask

  // Compare one instance against the model, then advance the model by one edge.
  task automatic model_cycle(input int i);
    logic        push;
    logic [1:0]  id;
    logic [5:0]  d;
    logic [3:0]  full;
    logic        exp_ready;
    logic [3:0]  exp_push;
    logic [5:0]  exp_data;
    logic [63:0] exp_cnt;
    bit          leaves;
    bit          dropped;
    bit          dm;
    int          cw;
    int          cmax;
    dm   = (i == 1);
    cw   = dm ? CW_DR : CW_BP;
    cmax = (1 << cw) - 1;
    if (i == 0) begin
      push = bp_if.PUSHDATOENTRADA; id = bp_if.ID; d = bp_if.DATOENTRADA; full = bp_if.FULL;
    end else begin
      push = dr_if.PUSHDATOENTRADA; id = dr_if.ID; d = dr_if.DATOENTRADA; full = dr_if.FULL;
    end
    leaves   = 1'b0;
    dropped  = 1'b0;
    exp_push = 4'b0000;
    if (RESET_L) begin
      if (m_valid[i]) begin
        if (!full[m_id[i]]) begin
          leaves             = 1'b1;
          exp_push[m_id[i]]  = 1'b1;
        end else if (dm) begin
          leaves  = 1'b1;
          dropped = 1'b1;
        end
      end
      exp_ready = !m_valid[i] || leaves;
      exp_data  = m_data[i];
    end else begin
      exp_ready = 1'b0;
      exp_data  = 6'h00;
    end
    exp_cnt = 64'd0;
    for (int k = 0; k < NCH; k++) exp_cnt |= 64'(m_cnt[i][k]) << (k * cw);
    chk_out(i, "rand", exp_ready, exp_push, exp_data);
    chk((i == 0) ? "rand.bp.dropcnt" : "rand.dr.dropcnt", act_cnt(i), exp_cnt);
    if (!RESET_L) begin
      m_valid[i] = 1'b0;
      m_id[i]    = 0;
      m_data[i]  = 6'h00;
      for (int k = 0; k < NCH; k++) m_cnt[i][k] = 0;
    end else begin
      if (dropped && (m_cnt[i][m_id[i]] < cmax)) m_cnt[i][m_id[i]]++;
      if (leaves) m_valid[i] = 1'b0;
      if (push && exp_ready) begin
        m_valid[i] = 1'b1;
        m_id[i]    = int'(id);
        m_data[i]  = d;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 6'h01, 4'b0000, 1'b1, 4'b0000, 6'h00};
    vecs[1]  = '{1'b1, 2'd1, 6'h02, 4'b0000, 1'b1, 4'b0001, 6'h01};
    vecs[2]  = '{1'b1, 2'd2, 6'h03, 4'b0000, 1'b1, 4'b0010, 6'h02};
    vecs[3]  = '{1'b1, 2'd3, 6'h04, 4'b0000, 1'b1, 4'b0100, 6'h03};
    vecs[4]  = '{1'b0, 2'd0, 6'h00, 4'b0000, 1'b1, 4'b1000, 6'h04};
    vecs[5]  = '{1'b0, 2'd0, 6'h00, 4'b0000, 1'b1, 4'b0000, 6'h04};
    vecs[6]  = '{1'b1, 2'd2, 6'h2A, 4'b0100, 1'b1, 4'b0000, 6'h04};
    vecs[7]  = '{1'b1, 2'd0, 6'h11, 4'b0100, 1'b0, 4'b0000, 6'h2A};
    vecs[8]  = '{1'b1, 2'd0, 6'h11, 4'b0100, 1'b0, 4'b0000, 6'h2A};
    vecs[9]  = '{1'b1, 2'd0, 6'h11, 4'b0000, 1'b1, 4'b0100, 6'h2A};
    vecs[10] = '{1'b0, 2'd0, 6'h00, 4'b0000, 1'b1, 4'b0001, 6'h11};
    vecs[11] = '{1'b0, 2'd0, 6'h00, 4'b0000, 1'b1, 4'b0000, 6'h11};

    // Reset held with a word offered upstream.
    RESET_L = 1'b0;
    drive(0, 1'b1, 2'd1, 6'h05, 4'b0000);
    drive(1, 1'b1, 2'd2, 6'h09, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge CLK);
      chk_out(0, "reset", 1'b0, 4'b0000, 6'h00);
      chk_out(1, "reset", 1'b0, 4'b0000, 6'h00);
      chk("reset.bp.dropcnt", act_cnt(0), 64'd0);
      chk("reset.dr.dropcnt", act_cnt(1), 64'd0);
    end
    tick();
    RESET_L = 1'b1;
    drive(0, 1'b0, 2'd0, 6'h00, 4'b0000);
    drive(1, 1'b0, 2'd0, 6'h00, 4'b0000);
    @(negedge CLK);
    chk_out(0, "release", 1'b1, 4'b0000, 6'h00);
    chk_out(1, "release", 1'b1, 4'b0000, 6'h00);
    tick();

    // Routing and backpressure on the hold-mode instance.
    for (int v = 0; v < 12; v++) begin
      drive(0, vecs[v].push, vecs[v].id, vecs[v].data, vecs[v].full);
      @(negedge CLK);
      chk_out(0, $sformatf("vec%0d", v), vecs[v].exp_ready, vecs[v].exp_push, vecs[v].exp_data);
      tick();
    end
    drive(0, 1'b0, 2'd0, 6'h00, 4'b0000);

    // Drop mode: five words into a full class 1.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b1, 2'd1, 6'(k + 1), 4'b0010);
      @(negedge CLK);
      chk("drop.ready", 64'(dr_if.READY), 64'd1);
      chk("drop.cfpush", 64'(dr_if.CFPUSH), 64'd0);
      tick();
    end
    drive(1, 1'b0, 2'd0, 6'h00, 4'b0010);
    @(negedge CLK);
    chk("drop.tail.cfpush", 64'(dr_if.CFPUSH), 64'd0);
    tick();
    @(negedge CLK);
    chk("drop.dropcnt", act_cnt(1), 64'h028);
    tick();

    // Saturation: ten drops into class 1-wide-3 counter of class 3.
    for (int k = 0; k < 10; k++) begin
      drive(1, 1'b1, 2'd3, 6'(k), 4'b1000);
      @(negedge CLK);
      chk("sat.ready", 64'(dr_if.READY), 64'd1);
      chk("sat.cfpush", 64'(dr_if.CFPUSH), 64'd0);
      tick();
    end
    drive(1, 1'b0, 2'd0, 6'h00, 4'b1000);
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("sat.dropcnt", act_cnt(1), 64'hE28);
    tick();
    drive(1, 1'b0, 2'd0, 6'h00, 4'b0000);

    // Reset while a word is held against a full FIFO.
    drive(0, 1'b1, 2'd2, 6'h15, 4'b0100);
    @(negedge CLK);
    chk("midrst.accept", 64'(bp_if.READY), 64'd1);
    tick();
    drive(0, 1'b0, 2'd0, 6'h00, 4'b0100);
    @(negedge CLK);
    chk_out(0, "midrst.held", 1'b0, 4'b0000, 6'h15);
    tick();
    RESET_L = 1'b0;
    @(negedge CLK);
    chk_out(0, "midrst.inrst", 1'b0, 4'b0000, 6'h00);
    tick();
    RESET_L = 1'b1;
    drive(0, 1'b0, 2'd0, 6'h00, 4'b0000);
    @(negedge CLK);
    chk_out(0, "midrst.after", 1'b1, 4'b0000, 6'h00);
    chk("midrst.dr.dropcnt", act_cnt(1), 64'd0);
    tick();
    @(negedge CLK);
    chk("midrst.nopush", 64'(bp_if.CFPUSH), 64'd0);
    tick();

    // Randomized traffic on both instances with occasional resets.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      RESET_L = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 2; i++) begin
        logic [3:0] f;
        for (int b = 0; b < NCH; b++) f[b] = ($urandom_range(0, 2) == 0);
        drive(i, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 63)), f);
      end
      @(negedge CLK);
      model_cycle(0);
      model_cycle(1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
